// File: rtl/data_sram_resp.sv
// Data-memory responder: one request at a time, byte-strobed stores into a word array, raw word returned for loads.
// Latency: data_ok pulses exactly LATENCY cycles after the accept cycle (LATENCY 1..15); one request per LATENCY+1 cycles.
// Backpressure: addr_ok is high only in IDLE; a req seen while busy is ignored, never queued.
module data_sram_resp #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  wr_q, wr_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           rdata_q, rdata_d;

  logic [31:0]           mem [DEPTH];

  logic [DEPTH_LOG2-1:0] req_idx;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic [31:0]           rd_word;
  logic                  addr_unused;

  // Bits above the array span alias; the byte offset is irrelevant for whole-word access.
  assign addr_unused = ^{addr[31:DEPTH_LOG2+2], addr[1:0]};
  assign req_idx     = addr[DEPTH_LOG2+1:2];
  // With LATENCY=1 the read happens on the accept edge, so it must use the live address.
  assign rd_idx      = (state_q == IDLE) ? req_idx : idx_q;
  assign rd_word     = mem[rd_idx];

  assign addr_ok = (state_q == IDLE);
  assign data_ok = (state_q == RESP);
  assign rdata   = rdata_q;

  // Next-state, request capture and response data selection.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    wstrb_d = wstrb_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          wr_d    = wr;
          wstrb_d = wstrb;
          idx_d   = req_idx;
          wdata_d = wdata;
          cnt_d   = CNT_INIT;
          if (LATENCY == 1) begin
            state_d = RESP;
            rdata_d = wr ? 32'd0 : rd_word;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = RESP;
          rdata_d = wr_q ? 32'd0 : rd_word;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and captured-request registers; reset drops any in-flight request.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      wstrb_q <= 4'd0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      wstrb_q <= wstrb_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Store commits on the edge ending RESP; a reset beforehand leaves state_q out of RESP so nothing is written.
  always_ff @(posedge clk) begin
    if (state_q == RESP && wr_q) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_q[i]) begin
          mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_sram_resp.sv
// Bench for data_sram_resp: a LATENCY=2 instance carries most vectors, a LATENCY=1 instance checks the short path.
// Latency: checked per transaction from the accept cycle to the data_ok cycle.
// Backpressure: addr_ok is checked idle before each request and low while busy.
module tb_data_sram_resp;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        req2, req1, wr;
  logic [3:0]  wstrb;
  logic [31:0] addr, wdata;
  logic        aok2, dok2, aok1, dok1;
  logic [31:0] rd2, rd1;

  int tests = 0;
  int fails = 0;

  data_sram_resp #(.DEPTH_LOG2(10), .LATENCY(2)) u_l2 (
    .clk(clk), .resetn(resetn), .req(req2), .wr(wr), .wstrb(wstrb), .addr(addr), .wdata(wdata),
    .addr_ok(aok2), .data_ok(dok2), .rdata(rd2)
  );

  data_sram_resp #(.DEPTH_LOG2(10), .LATENCY(1)) u_l1 (
    .clk(clk), .resetn(resetn), .req(req1), .wr(wr), .wstrb(wstrb), .addr(addr), .wdata(wdata),
    .addr_ok(aok1), .data_ok(dok1), .rdata(rd1)
  );

  typedef struct {
    logic        w;
    logic [3:0]  s;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t        vt [13];
  int          acc [4];
  int          dokc [4];
  logic [31:0] rdv [4];
  logic        w5 [4];
  logic [31:0] d5 [4];
  int          n, nd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // One complete transaction on the selected instance (sel=1 -> LATENCY=1 instance).
  task automatic do_op(input bit sel, input logic w, input logic [3:0] s, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] exp, input string nm);
    int          lat;
    logic        aok, dok;
    logic [31:0] rd;
    @(negedge clk);
    aok = sel ? aok1 : aok2;
    chk({nm, "_addr_ok_idle"}, 32'(aok), 32'd1);
    wr = w; wstrb = s; addr = a; wdata = d;
    if (sel) req1 = 1'b1; else req2 = 1'b1;
    @(negedge clk);
    req1 = 1'b0; req2 = 1'b0;
    wr = 1'($urandom); wstrb = 4'($urandom); addr = $urandom; wdata = $urandom;
    aok = sel ? aok1 : aok2;
    chk({nm, "_addr_ok_busy"}, 32'(aok), 32'd0);
    lat = 1;
    dok = sel ? dok1 : dok2;
    while (!dok && lat < 20) begin
      @(negedge clk);
      lat++;
      dok = sel ? dok1 : dok2;
    end
    chk({nm, "_latency"}, 32'(lat), sel ? 32'd1 : 32'd2);
    rd = sel ? rd1 : rd2;
    chk({nm, "_rdata"}, rd, exp);
    @(negedge clk);
    dok = sel ? dok1 : dok2;
    chk({nm, "_pulse_end"}, 32'(dok), 32'd0);
    if (!w) begin
      rd = sel ? rd1 : rd2;
      chk({nm, "_rdata_hold"}, rd, exp);
    end
  endtask

  initial begin
    vt[0]  = '{1'b1, 4'b1111, 32'h10,   32'h12345678, 32'h0};
    vt[1]  = '{1'b0, 4'b0000, 32'h10,   32'h0,        32'h12345678};
    vt[2]  = '{1'b1, 4'b0100, 32'h12,   32'hAAAAAAAA, 32'h0};
    vt[3]  = '{1'b0, 4'b0000, 32'h10,   32'h0,        32'h12AA5678};
    vt[4]  = '{1'b1, 4'b0000, 32'h10,   32'hFFFFFFFF, 32'h0};
    vt[5]  = '{1'b0, 4'b1111, 32'h10,   32'h0,        32'h12AA5678};
    vt[6]  = '{1'b1, 4'b1111, 32'h14,   32'h0,        32'h0};
    vt[7]  = '{1'b1, 4'b1100, 32'h14,   32'hBEEFBEEF, 32'h0};
    vt[8]  = '{1'b0, 4'b0000, 32'h14,   32'h0,        32'hBEEF0000};
    vt[9]  = '{1'b0, 4'b0000, 32'h1010, 32'h0,        32'h12AA5678};
    vt[10] = '{1'b0, 4'b0000, 32'h13,   32'h0,        32'h12AA5678};
    vt[11] = '{1'b1, 4'b1111, 32'h20,   32'h11111111, 32'h0};
    vt[12] = '{1'b0, 4'b0000, 32'h20,   32'h0,        32'h11111111};

    // Reset held with req asserted.
    resetn = 1'b0; req1 = 1'b1; req2 = 1'b1;
    wr = 1'b1; wstrb = 4'hF; addr = 32'h10; wdata = 32'hFFFFFFFF;
    repeat (3) @(negedge clk);
    chk("rst_data_ok_l2", 32'(dok2), 32'd0);
    chk("rst_rdata_l2", rd2, 32'd0);
    chk("rst_data_ok_l1", 32'(dok1), 32'd0);
    chk("rst_rdata_l1", rd1, 32'd0);
    req1 = 1'b0; req2 = 1'b0;
    resetn = 1'b1;
    @(negedge clk);
    chk("rel_addr_ok_l2", 32'(aok2), 32'd1);
    chk("rel_addr_ok_l1", 32'(aok1), 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rel_no_data_ok_%0d", i), {30'd0, dok2, dok1}, 32'd0);
      @(negedge clk);
    end

    // Directed table on the LATENCY=2 instance.
    for (int i = 0; i < 13; i++) begin
      do_op(1'b0, vt[i].w, vt[i].s, vt[i].a, vt[i].d, vt[i].exp, $sformatf("vec%0d", i));
    end

    // req held high over four alternating requests; each load follows its store immediately.
    w5[0] = 1'b1; w5[1] = 1'b0; w5[2] = 1'b1; w5[3] = 1'b0;
    d5[0] = 32'hA5A5A5A5; d5[1] = 32'h0; d5[2] = 32'h5A5A5A5A; d5[3] = 32'h0;
    for (int i = 0; i < 4; i++) begin
      acc[i] = -100; dokc[i] = -100; rdv[i] = 32'hX;
    end
    n = 0; nd = 0;
    for (int cyc = 0; cyc < 40 && nd < 4; cyc++) begin
      @(negedge clk);
      if (dok2) begin
        if (nd < 4) begin
          dokc[nd] = cyc;
          rdv[nd]  = rd2;
        end
        nd++;
      end
      if (n < 4) begin
        req2 = 1'b1; wr = w5[n]; wstrb = 4'hF; addr = 32'h30; wdata = d5[n];
      end else begin
        req2 = 1'b0;
      end
      if (aok2 && n < 4) begin
        acc[n] = cyc;
        n++;
      end
    end
    req2 = 1'b0;
    chk("b2b_responses", 32'(nd), 32'd4);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("b2b_accept_gap_%0d", i), 32'(acc[i+1] - acc[i]), 32'd3);
    end
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("b2b_latency_%0d", i), 32'(dokc[i] - acc[i]), 32'd2);
    end
    chk("b2b_raw_load1", rdv[1], 32'hA5A5A5A5);
    chk("b2b_raw_load3", rdv[3], 32'h5A5A5A5A);
    chk("b2b_store_rdata0", rdv[0], 32'h0);

    // LATENCY=1 instance.
    do_op(1'b1, 1'b1, 4'b1111, 32'h40,   32'hCAFEF00D, 32'h0,        "l1_store");
    do_op(1'b1, 1'b0, 4'b0000, 32'h40,   32'h0,        32'hCAFEF00D, "l1_load");
    do_op(1'b1, 1'b0, 4'b0000, 32'h1040, 32'h0,        32'hCAFEF00D, "l1_alias");

    // Reset while a store sits in WAIT: no pulse, store not committed.
    @(negedge clk);
    req2 = 1'b1; wr = 1'b1; wstrb = 4'hF; addr = 32'h20; wdata = 32'hDEADBEEF;
    @(negedge clk);
    req2 = 1'b0;
    chk("t6_in_wait", 32'(aok2), 32'd0);
    #1 resetn = 1'b0;
    #1;
    chk("t6_rst_data_ok", 32'(dok2), 32'd0);
    chk("t6_rst_rdata", rd2, 32'd0);
    chk("t6_rst_addr_ok", 32'(aok2), 32'd1);
    repeat (2) begin
      @(negedge clk);
      chk("t6_held_data_ok", 32'(dok2), 32'd0);
    end
    resetn = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t6_after_data_ok", 32'(dok2), 32'd0);
    end
    do_op(1'b0, 1'b0, 4'b0000, 32'h20, 32'h0, 32'h11111111, "t6_load");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
